// File: rtl/spi_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_access_arbiter_if
//
// Bundles the requester handshake and the SPI engine go/data/end signals that
// pass through spi_access_arbiter.
//
//   master : the arbiter itself (drives grants, done/err, go and the frame).
//   slave  : the surroundings (requesters drive iREQ/iREQ_DATA, the
//            Send_and_Receive engine drives iSPI_END).
//
// Signals
//   iREQ       NREQ     per-requester request level
//   iREQ_DATA  NREQ*DW  per-requester command frame, requester i at [i*DW +: DW]
//   oGNT       NREQ     one-hot grant, high for the whole owned transfer
//   oDONE      NREQ     one-cycle completion pulse to the granted requester
//   oERR       1        one-cycle timeout pulse, coincident with oDONE
//   oBUSY      1        high while a transfer is owned
//   oSPI_GO    1        one-cycle start pulse to the engine
//   oDATA_P2S  DW       command frame to the engine, stable while oBUSY
//   iSPI_END   1        engine end flag (rising edge marks completion)
// -----------------------------------------------------------------------------
interface spi_access_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 16
);

    logic [NREQ-1:0]    iREQ;
    logic [NREQ*DW-1:0] iREQ_DATA;
    logic [NREQ-1:0]    oGNT;
    logic [NREQ-1:0]    oDONE;
    logic               oERR;
    logic               oBUSY;
    logic               oSPI_GO;
    logic [DW-1:0]      oDATA_P2S;
    logic               iSPI_END;

    modport master (
        input  iREQ,
        input  iREQ_DATA,
        input  iSPI_END,
        output oGNT,
        output oDONE,
        output oERR,
        output oBUSY,
        output oSPI_GO,
        output oDATA_P2S
    );

    modport slave (
        output iREQ,
        output iREQ_DATA,
        output iSPI_END,
        input  oGNT,
        input  oDONE,
        input  oERR,
        input  oBUSY,
        input  oSPI_GO,
        input  oDATA_P2S
    );

endinterface

// File: rtl/spi_access_arbiter.sv
// -----------------------------------------------------------------------------
// spi_access_arbiter
//
// Shares the single SPI transfer engine (Send_and_Receive) between NREQ
// register-access requesters (init-table writer, periodic X/Y reader, host
// port). One requester owns the engine at a time; ownership is handed out
// round-robin starting after the last served requester. The block pulses the
// engine go, holds the latched frame on oDATA_P2S, and ends the transfer on a
// rising edge of iSPI_END or, failing that, after TIMEOUT busy cycles.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   DW       command frame width, {mode[1:0], addr[5:0], data[7:0]} for DW=16
//   TIMEOUT  busy cycles allowed before the transfer is aborted (>= 2)
//
// Ports
//   iSPI_CLK  block clock, shared with the engine control side
//   iRST      asynchronous reset, active-high
//   bus       spi_access_arbiter_if.master (requests, grants, engine handshake)
// -----------------------------------------------------------------------------
module spi_access_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic                  iSPI_CLK,
    input logic                  iRST,
    spi_access_arbiter_if.master bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TimerSat  = TW'(TIMEOUT);
    localparam logic [IW-1:0] IdxLast   = IW'(NREQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [IW-1:0]   gidx_q,  gidx_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic            err_q,   err_d;
    logic            busy_q,  busy_d;
    logic            go_q,    go_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            end_q;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [DW-1:0]   pick_frame;
    logic            complete;

    // -------------------------------------------------------------------------
    // Round-robin pick: first request found walking upward from last+1,
    // wrapping at NREQ. The last-served requester is examined last, so a
    // requester that re-requests right after its done queues behind the rest.
    // -------------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_q) + k) % NREQ;
            if (!pick_vld && bus.iREQ[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    // Frame of the picked requester.
    always_comb begin
        pick_frame = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_frame = bus.iREQ_DATA[i*DW +: DW];
            end
        end
    end

    // Only a fresh rise counts; a level left high from the previous frame
    // is already captured in end_q and is ignored until it falls and rises.
    assign complete = bus.iSPI_END & ~end_q;

    // -------------------------------------------------------------------------
    // Next-state and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        go_d    = 1'b0;
        data_d  = data_q;
        timer_d = timer_q;

        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    state_d = StBusy;
                    gnt_d   = NREQ'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    data_d  = pick_frame;
                    go_d    = 1'b1;
                    busy_d  = 1'b1;
                    timer_d = '0;
                end
            end

            StBusy: begin
                if (timer_q != TimerSat) begin
                    timer_d = timer_q + TW'(1);
                end
                // Completion wins over a timeout landing in the same cycle.
                if (complete || (timer_q == TimerLast)) begin
                    state_d = StIdle;
                    done_d  = gnt_q;
                    err_d   = ~complete;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = gidx_q;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iSPI_CLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= IdxLast;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
            data_q  <= '0;
            timer_q <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            end_q   <= bus.iSPI_END;
        end
    end

    assign bus.oGNT      = gnt_q;
    assign bus.oDONE     = done_q;
    assign bus.oERR      = err_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oSPI_GO   = go_q;
    assign bus.oDATA_P2S = data_q;

endmodule

// File: doc/spi_access_arbiter.md
# spi_access_arbiter

Round-robin arbiter and sequencer that shares the single SPI transfer engine (Send_and_Receive) between several register-access requesters: the init-table writer, the periodic X/Y data reader, and the on-demand host access port. It grants one requester at a time, drives the engine's go/data handshake, and detects completion from the engine's end flag. A watchdog aborts a transfer that never completes. It sits between the requesters and Send_and_Receive, replacing the inline go/state logic in the top controller.

## Interface
- NREQ, 3: number of requesters; legal range 2..8.
- DW, 16: SPI command frame width, laid out as {mode[1:0], addr[5:0], data[7:0]}.
- TIMEOUT, 4096: maximum number of BUSY cycles allowed before abort; must be at least 2.

- iSPI_CLK  in  1  block clock; the only clock, shared with the SPI engine control side.
- iRST  in  1  asynchronous reset, active-high.
- iREQ  in  NREQ  per-requester request level.
- iREQ_DATA  in  NREQ*DW  per-requester command frame; requester i uses bits [i*DW +: DW].
- oGNT  out  NREQ  one-hot grant; high throughout the owned transfer.
- oDONE  out  NREQ  one-cycle completion pulse to the granted requester.
- oERR  out  1  one-cycle timeout pulse, coincident with oDONE.
- oBUSY  out  1  high while a transfer is owned.
- oSPI_GO  out  1  one-cycle start pulse to the engine.
- oDATA_P2S  out  DW  command frame to the engine; held stable while oBUSY is high.
- iSPI_END  in  1  engine end flag; only its rising edge is used.

## Operation
- Two states, IDLE and BUSY. Reset puts the block in IDLE.
- Reset values:
  - oGNT=0, oDONE=0, oERR=0, oBUSY=0, oSPI_GO=0, oDATA_P2S=0.
  - Timer=0, end_d=0.
  - Last-grant pointer = NREQ-1, so requester 0 wins the first arbitration.
- IDLE behaviour:
  - If any iREQ bit is high, pick the first set bit searching upward from last+1, wrapping modulo NREQ.
  - Latch that requester's frame into oDATA_P2S, set oGNT to its one-hot code, pulse oSPI_GO, set oBUSY, clear the timer, and move to BUSY.
  - If no request is high, stay in IDLE with all outputs idle.
- BUSY behaviour:
  - The timer increments every cycle.
  - end_d registers iSPI_END every cycle in both states; completion is iSPI_END & ~end_d.
  - On completion: pulse oDONE[g], clear oGNT and oBUSY, set last=g, return to IDLE.
  - If the timer reaches TIMEOUT-1 with no completion: pulse oDONE[g] and oERR, clear oGNT and oBUSY, set last=g, return to IDLE. No retry.
- Request rules:
  - A requester holds iREQ high until it sees its oDONE.
  - Dropping iREQ before grant withdraws the request.
  - iREQ and iREQ_DATA are ignored once granted, because the frame is already latched.
  - If iREQ is still high in the cycle after oDONE, it is a new request and is arbitrated normally, so it goes behind the other pending requesters.
- Timer width is $clog2(TIMEOUT+1) bits. The timer saturates and never wraps.

## Timing
- A request sampled in IDLE at edge t produces oSPI_GO=1, oGNT, oBUSY and a valid oDATA_P2S in the cycle after t. oSPI_GO is exactly one cycle wide.
- A rising edge of iSPI_END sampled at edge e produces, in the next cycle:
  - oDONE pulse;
  - oGNT=0 and oBUSY=0;
  - state IDLE.
  A pending request then gets oSPI_GO one cycle later still. Minimum back-to-back spacing is 2 cycles between the end edge and the next oSPI_GO.
- iSPI_END already high when BUSY is entered, left over from the previous frame, is not a completion; the block waits for a fall and a new rise.
- Completion and timeout in the same cycle: treated as normal completion, oERR=0.
- All requesters asserting at once: grants rotate 0,1,2,0,… and each requester waits at most NREQ-1 transfers.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronous). No oDONE is issued. Pointer returns to NREQ-1.

## Test plan
- Reset, then iREQ=3'b001 with frame 16'h2C09 → next cycle oSPI_GO=1 for one cycle, oGNT=001, oDATA_P2S=16'h2C09. Pulse iSPI_END 10 cycles later → oDONE=001 one cycle after the edge, oBUSY=0.
- iREQ=3'b111 held, engine ends each frame after 5 cycles → grant order 0,1,2,0. Each oDONE is a single cycle, and oSPI_GO pulses are at least 2 cycles after each end edge.
- iSPI_END held high across oSPI_GO → no completion. Drop iSPI_END, then raise it → oDONE.
- No iSPI_END edge for TIMEOUT=8 → oDONE and oERR pulse together exactly 8 cycles after oSPI_GO; the next request is granted normally.
- iSPI_END rising edge in the same cycle the timer reaches TIMEOUT-1 → oDONE=1, oERR=0.
- iRST pulsed high mid-BUSY → oGNT, oBUSY and oSPI_GO go to 0 immediately, no oDONE. After release, iREQ=3'b110 → requester 1 is granted first.
